// File: rtl/cordic_sin_cos.sv
// Iterative rotation-mode CORDIC: sine/cosine of an 8-bit first-quadrant angle.
// One micro-rotation per clock; the result is held with DONE until the next reset.
module cordic_sin_cos #(
  parameter int ITER   = 8,
  parameter int XY_W   = 16,
  parameter int K_INIT = 9949
) (
  input  logic            CLK,
  input  logic            RESET_PULSE,
  input  logic [7:0]      INPUT_ANGLE,
  output logic [7:0]      LUT_ANGLE,
  output logic [XY_W-1:0] SIN_OUT,
  output logic [XY_W-1:0] COS_OUT,
  output logic            DONE
);

  localparam int I_W = $clog2(ITER);
  localparam int Z_W = 10;

  typedef enum logic [1:0] {S_LOAD, S_ITER, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic signed [XY_W-1:0] r_x, r_y, r_sin, r_cos;
  logic signed [XY_W-1:0] w_x_nxt, w_y_nxt, w_x_sh, w_y_sh;
  logic signed [Z_W-1:0]  r_z, w_z_nxt, w_lut_ext;
  logic [I_W-1:0]         r_i;
  logic [7:0]             w_lut;
  logic                   w_d, w_last, r_done;

  // atan(2^-i) with 256 units per 90 degrees
  function automatic logic [7:0] atan_lut(input logic [I_W-1:0] idx);
    case (idx)
      3'd0:    return 8'd128;
      3'd1:    return 8'd76;
      3'd2:    return 8'd40;
      3'd3:    return 8'd20;
      3'd4:    return 8'd10;
      3'd5:    return 8'd5;
      3'd6:    return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic signed [XY_W-1:0] asr(input logic signed [XY_W-1:0] v,
                                                 input logic [I_W-1:0] sh);
    return v >>> sh;
  endfunction

  always_comb begin
    w_lut     = atan_lut(r_i);
    w_lut_ext = signed'({2'b00, w_lut});
    w_d       = ~r_z[Z_W-1];
    w_x_sh    = asr(r_x, r_i);
    w_y_sh    = asr(r_y, r_i);
    w_last    = (r_i == I_W'(ITER - 1));
    if (w_d) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_lut_ext;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_lut_ext;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  w_state_nxt = S_ITER;
      S_ITER:  if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_PULSE) begin
    if (!RESET_PULSE) begin
      r_state <= S_LOAD;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_LOAD: begin
          r_x <= XY_W'(K_INIT);
          r_y <= '0;
          r_z <= signed'({2'b00, INPUT_ANGLE});
          r_i <= '0;
        end
        S_ITER: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + 1'b1;
          // residual Z is simply dropped once the last rotation lands
          if (w_last) begin
            r_sin  <= w_y_nxt;
            r_cos  <= w_x_nxt;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign LUT_ANGLE = (r_state == S_ITER) ? w_lut : 8'd0;
  assign SIN_OUT   = r_sin;
  assign COS_OUT   = r_cos;
  assign DONE      = r_done;

endmodule

// File: tb/tb_cordic_sin_cos.sv
// Bench for cordic_sin_cos: table of angles with a queued reference model,
// plus hand-written sequences for hold, async abort, mid-run input change and clockless release.
module tb_cordic_sin_cos;

  logic        CLK = 1'b0;
  logic        RESET_PULSE = 1'b0;
  logic [7:0]  INPUT_ANGLE = 8'd0;
  logic [7:0]  LUT_ANGLE;
  logic [15:0] SIN_OUT, COS_OUT;
  logic        DONE;
  bit          clk_en = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] angle;
    int         ap_s;
    int         ap_c;
  } vec_t;

  typedef struct {
    int ex_s;
    int ex_c;
    int ap_s;
    int ap_c;
  } sb_t;

  sb_t sb_q[$];
  int  lut_ref[8] = '{128, 76, 40, 20, 10, 5, 3, 1};

  cordic_sin_cos dut (
    .CLK         (CLK),
    .RESET_PULSE (RESET_PULSE),
    .INPUT_ANGLE (INPUT_ANGLE),
    .LUT_ANGLE   (LUT_ANGLE),
    .SIN_OUT     (SIN_OUT),
    .COS_OUT     (COS_OUT),
    .DONE        (DONE)
  );

  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int diff;
    checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
    end
  endtask

  // Straight CORDIC recurrence in integers, truncating arithmetic shifts
  function automatic void model(input int a, output int s, output int c);
    int x, y, z, xn;
    x = 9949; y = 0; z = a;
    for (int i = 0; i < 8; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - lut_ref[i];
      end else begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + lut_ref[i];
      end
      x = xn;
    end
    s = y;
    c = x;
  endfunction

  task automatic run_angle(input logic [7:0] a, input int ap_s, input int ap_c,
                           input bit chg, input logic [7:0] a2);
    sb_t e, got;
    int  k;
    bit  seen;
    RESET_PULSE = 1'b0;
    INPUT_ANGLE = a;
    #1;
    check("rst_done", DONE, 0);
    check("rst_sin", $signed(SIN_OUT), 0);
    check("rst_cos", $signed(COS_OUT), 0);
    @(negedge CLK);
    model(a, e.ex_s, e.ex_c);
    e.ap_s = ap_s;
    e.ap_c = ap_c;
    sb_q.push_back(e);
    RESET_PULSE = 1'b1;
    check("load_lut", LUT_ANGLE, 0);
    seen = 1'b0;
    k = 0;
    while (k < 20 && !seen) begin
      @(negedge CLK);
      k++;
      if (k == 1 && chg) INPUT_ANGLE = a2;
      if (k <= 8) begin
        check($sformatf("lut_%0d_k%0d", a, k), LUT_ANGLE, lut_ref[k-1]);
        check("done_early", DONE, 0);
      end
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      check($sformatf("latency_%0d", a), k, 9);
      check("lut_after_done", LUT_ANGLE, 0);
      if (sb_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        got = sb_q.pop_front();
        check($sformatf("sin_exact_%0d", a), $signed(SIN_OUT), got.ex_s);
        check($sformatf("cos_exact_%0d", a), $signed(COS_OUT), got.ex_c);
        check_tol($sformatf("sin_approx_%0d", a), $signed(SIN_OUT), got.ap_s, 200);
        check_tol($sformatf("cos_approx_%0d", a), $signed(COS_OUT), got.ap_c, 200);
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   hs, hc;
    tbl[0] = '{8'd210, 15760, 4470};
    tbl[1] = '{8'd94,  8934,  13735};
    tbl[2] = '{8'd0,   0,     16384};
    tbl[3] = '{8'd255, 16384, 100};
    tbl[4] = '{8'd128, 11585, 11585};

    #12;
    check("init_done", DONE, 0);
    check("init_lut", LUT_ANGLE, 0);

    foreach (tbl[i]) run_angle(tbl[i].angle, tbl[i].ap_s, tbl[i].ap_c, 1'b0, 8'd0);

    // Hold in DONE while the input angle moves
    model(128, hs, hc);
    INPUT_ANGLE = 8'd94;
    repeat (5) @(negedge CLK);
    check("hold_sin", $signed(SIN_OUT), hs);
    check("hold_cos", $signed(COS_OUT), hc);
    check("hold_done", DONE, 1);
    check("hold_lut", LUT_ANGLE, 0);

    // Asynchronous clear of a held result, away from any clock edge
    #2 RESET_PULSE = 1'b0;
    #1;
    check("async_sin", $signed(SIN_OUT), 0);
    check("async_cos", $signed(COS_OUT), 0);
    check("async_done", DONE, 0);

    // Abort in the middle of a run
    @(negedge CLK);
    INPUT_ANGLE = 8'd210;
    RESET_PULSE = 1'b1;
    repeat (4) @(negedge CLK);
    check("mid_lut", LUT_ANGLE, 20);
    #2 RESET_PULSE = 1'b0;
    #1;
    check("abort_lut", LUT_ANGLE, 0);
    check("abort_done", DONE, 0);
    check("abort_sin", $signed(SIN_OUT), 0);
    run_angle(8'd210, 15760, 4470, 1'b0, 8'd0);

    // Input changes after the load edge must not disturb the run
    run_angle(8'd94, 8934, 13735, 1'b1, 8'd255);

    // Release with the clock stopped: nothing may move
    @(negedge CLK);
    clk_en = 1'b0;
    RESET_PULSE = 1'b0;
    #20 RESET_PULSE = 1'b1;
    #40;
    check("noclk_done", DONE, 0);
    check("noclk_lut", LUT_ANGLE, 0);
    check("noclk_sin", $signed(SIN_OUT), 0);
    check("noclk_cos", $signed(COS_OUT), 0);
    clk_en = 1'b1;
    run_angle(8'd0, 0, 16384, 1'b0, 8'd0);

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
